// File: rtl/sar_pkg.sv
// Shared types and helpers for the SAR sequencer: FSM state encoding,
// mid-scale code generation and bit-pointer sizing.
package sar_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SAMPLE  = 3'd1,
        COMPARE = 3'd2,
        DECIDE  = 3'd3,
        DONE    = 3'd4
    } sar_state_e;

    localparam int unsigned NDAC_DEFAULT = 32'd16;
    localparam int unsigned PTR_W        = $clog2(NDAC_DEFAULT);

    // Pointer width for an n-bit converter; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

    // Mid-scale trial code: MSB set, all other bits clear (n <= 32).
    function automatic logic [31:0] mid_code(input int unsigned n);
        return 32'd1 << (n - 32'd1);
    endfunction

endpackage

// File: rtl/sar_bitreg.sv
// Successive-approximation trial register and bit pointer. init loads
// mid-scale and points at the MSB; step applies one comparator decision.
module sar_bitreg
    import sar_pkg::*;
#(
    parameter int unsigned Ndac = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            init,
    input  logic            step,
    input  logic            comp_out,
    output logic [Ndac-1:0] code,
    output logic            last
);

    localparam int unsigned     PW      = ptr_width(Ndac);
    localparam logic [Ndac-1:0] MID     = Ndac'(mid_code(Ndac));
    localparam logic [PW-1:0]   PTR_TOP = PW'(Ndac - 1);

    logic [Ndac-1:0] code_q;
    logic [Ndac-1:0] code_d;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   ptr_d;

    // Next trial word: a high decision drops the bit under test, then the
    // next lower bit is tried unless the LSB has just been resolved.
    always_comb begin
        code_d = code_q;
        ptr_d  = ptr_q;
        if (init) begin
            code_d = MID;
            ptr_d  = PTR_TOP;
        end else if (step) begin
            if (comp_out) begin
                code_d[ptr_q] = 1'b0;
            end else begin
                code_d[ptr_q] = code_q[ptr_q];
            end
            if (ptr_q != {PW{1'b0}}) begin
                code_d[ptr_q - PW'(1)] = 1'b1;
                ptr_d                  = ptr_q - PW'(1);
            end else begin
                ptr_d = ptr_q;
            end
        end else begin
            code_d = code_q;
        end
    end

    // Trial register and pointer state.
    always_ff @(posedge clk) begin
        if (rst) begin
            code_q <= {Ndac{1'b0}};
            ptr_q  <= {PW{1'b0}};
        end else begin
            code_q <= code_d;
            ptr_q  <= ptr_d;
        end
    end

    assign code = code_q;
    assign last = (ptr_q == {PW{1'b0}});

endmodule

// File: rtl/sar_ctrl.sv
// SAR conversion sequencer: sampling, per-bit comparator strobes, result
// handshake. Optional over_range flag is built when SAR_OVR_EN is defined.
module sar_ctrl
    import sar_pkg::*;
#(
    parameter int unsigned Ndac   = 16,
    parameter int unsigned Ntrack = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            samp,
    output logic            comp_clk,
    input  logic            comp_out,
    output logic [Ndac-1:0] cap_botplate,
    output logic [Ndac-1:0] cap_botplate_d,
    output logic [Ndac-1:0] dout,
    output logic            dout_valid,
`ifdef SAR_OVR_EN
    output logic            over_range,
`endif
    input  logic            dout_ready
);

    localparam int unsigned   CNT_W    = (Ntrack > 1) ? $clog2(Ntrack) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Ntrack - 1);

    sar_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            busy_q, samp_q, comp_clk_q;
    logic [Ndac-1:0] dout_q, dout_d;
    logic            dout_valid_q, dout_valid_d;
    logic [Ndac-1:0] cap_dly_q;
    logic [Ndac-1:0] code_s;
    logic [Ndac-1:0] final_s;
    logic            last_s;
    logic            init_s;
    logic            step_s;
`ifdef SAR_OVR_EN
    logic            over_q, over_d;
`endif

    sar_bitreg #(.Ndac(Ndac)) u_bitreg (
        .clk      (clk),
        .rst      (rst),
        .init     (init_s),
        .step     (step_s),
        .comp_out (comp_out),
        .code     (code_s),
        .last     (last_s)
    );

    // Word that the LSB decision produces; loaded into dout on the last step.
    always_comb begin
        final_s    = code_s;
        final_s[0] = code_s[0] & ~comp_out;
    end

    // Next-state, tracking counter and result handshake.
    always_comb begin
        state_d      = state_q;
        cnt_d        = {CNT_W{1'b0}};
        init_s       = 1'b0;
        step_s       = 1'b0;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
`ifdef SAR_OVR_EN
        over_d       = over_q;
`endif
        case (state_q)
            IDLE: begin
                init_s = 1'b1;
                if (start) begin
                    state_d = SAMPLE;
                end else begin
                    state_d = IDLE;
                end
            end
            SAMPLE: begin
                init_s = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = COMPARE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            COMPARE: begin
                state_d = DECIDE;
            end
            DECIDE: begin
                step_s = 1'b1;
                if (last_s) begin
                    dout_d       = final_s;
                    dout_valid_d = 1'b1;
`ifdef SAR_OVR_EN
                    over_d       = (final_s == {Ndac{1'b1}}) || (final_s == {Ndac{1'b0}});
`endif
                    state_d      = DONE;
                end else begin
                    state_d = COMPARE;
                end
            end
            DONE: begin
                if (dout_ready) begin
                    dout_valid_d = 1'b0;
`ifdef SAR_OVR_EN
                    over_d       = 1'b0;
`endif
                    // A start on the handshake cycle re-enters sampling at once.
                    init_s  = start;
                    state_d = start ? SAMPLE : IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter, result and registered control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            busy_q       <= 1'b0;
            samp_q       <= 1'b0;
            comp_clk_q   <= 1'b0;
            dout_q       <= {Ndac{1'b0}};
            dout_valid_q <= 1'b0;
            cap_dly_q    <= {Ndac{1'b0}};
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            busy_q       <= (state_d != IDLE);
            samp_q       <= (state_d == SAMPLE);
            comp_clk_q   <= (state_d == COMPARE);
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            cap_dly_q    <= code_s;
        end
    end

`ifdef SAR_OVR_EN
    // Range flag travels with dout.
    always_ff @(posedge clk) begin
        if (rst) begin
            over_q <= 1'b0;
        end else begin
            over_q <= over_d;
        end
    end

    assign over_range = over_q;
`endif

    assign busy           = busy_q;
    assign samp           = samp_q;
    assign comp_clk       = comp_clk_q;
    assign cap_botplate   = code_s;
    assign cap_botplate_d = cap_dly_q;
    assign dout           = dout_q;
    assign dout_valid     = dout_valid_q;

endmodule

// File: tb/tb_sar_ctrl.sv
// Directed bench for sar_ctrl (Ndac=16, Ntrack=2) with a behavioural
// comparator model; checks over_range as well when SAR_OVR_EN is defined.
module tb_sar_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        comp_out = 1'b0;
    logic        dout_ready = 1'b1;
    logic        busy, samp, comp_clk, dout_valid;
    logic [15:0] cap_botplate, cap_botplate_d, dout;
`ifdef SAR_OVR_EN
    logic        over_range;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] vin = 16'h0000;
    int          mode = 0;
    logic        mon_en = 1'b0;
    logic        rst_last = 1'b1;
    logic [15:0] cap_prev = 16'h0000;
    logic        valid_prev = 1'b0;
    int          comp_cnt = 0;
    int          samp_cnt = 0;
    int          valid_rise = 0;

    sar_ctrl #(.Ndac(16), .Ntrack(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .busy           (busy),
        .samp           (samp),
        .comp_clk       (comp_clk),
        .comp_out       (comp_out),
        .cap_botplate   (cap_botplate),
        .cap_botplate_d (cap_botplate_d),
        .dout           (dout),
        .dout_valid     (dout_valid),
`ifdef SAR_OVR_EN
        .over_range     (over_range),
`endif
        .dout_ready     (dout_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Comparator model, delay-line checker and event counters.
    always @(negedge clk) begin
        if (mon_en && !rst_last) check("cap_d", {16'h0, cap_botplate_d}, {16'h0, cap_prev});
        cap_prev = cap_botplate;
        rst_last = rst;
        comp_cnt += int'(comp_clk);
        samp_cnt += int'(samp);
        if (dout_valid && !valid_prev) valid_rise++;
        valid_prev = dout_valid;
        case (mode)
            1:       comp_out = 1'b0;
            2:       comp_out = 1'b1;
            default: comp_out = (cap_botplate > vin);
        endcase
    end

    task automatic clear_counts();
        comp_cnt   = 0;
        samp_cnt   = 0;
        valid_rise = 0;
    endtask

    // One conversion with dout_ready high; optional start pulse at cycle pk.
    task automatic run_conv(input string name, input logic [15:0] v, input int m,
                            input int pk, input logic [15:0] exp);
        int lat;
        logic [15:0] got;
        vin = v;
        mode = m;
        dout_ready = 1'b1;
        clear_counts();
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        check({name, "_samp0"}, {31'h0, samp}, 32'h1);
        check({name, "_busy0"}, {31'h0, busy}, 32'h1);
        check({name, "_cap0"}, {16'h0, cap_botplate}, 32'h8000);
        while (dout_valid !== 1'b1 && lat < 100) begin
            if (lat == pk) start = 1'b1;
            tick();
            start = 1'b0;
            lat++;
        end
        got = dout;
        check({name, "_lat"}, lat, 35);
        check({name, "_dout"}, {16'h0, got}, {16'h0, exp});
        check({name, "_cap_done"}, {16'h0, cap_botplate}, {16'h0, exp});
`ifdef SAR_OVR_EN
        check({name, "_ovr"}, {31'h0, over_range},
              {31'h0, (exp == 16'hFFFF) || (exp == 16'h0000)});
`endif
        tick();
        check({name, "_valid_clr"}, {31'h0, dout_valid}, 32'h0);
`ifdef SAR_OVR_EN
        check({name, "_ovr_clr"}, {31'h0, over_range}, 32'h0);
`endif
        tick();
        tick();
        check({name, "_comp_n"}, comp_cnt, 16);
        check({name, "_samp_n"}, samp_cnt, 2);
        check({name, "_vrise"}, valid_rise, 1);
        check({name, "_busy_end"}, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        int lat;
        int bad;
        logic [15:0] d0;

        // Reset state.
        rst = 1'b1;
        tick();
        tick();
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_samp", {31'h0, samp}, 32'h0);
        check("rst_comp_clk", {31'h0, comp_clk}, 32'h0);
        check("rst_valid", {31'h0, dout_valid}, 32'h0);
        check("rst_cap", {16'h0, cap_botplate}, 32'h0);
        check("rst_cap_d", {16'h0, cap_botplate_d}, 32'h0);
        check("rst_dout", {16'h0, dout}, 32'h0);
        mon_en = 1'b1;

        // Start on the first cycle out of reset: cap_d must show the old 0.
        rst = 1'b0;
        run_conv("a5c3", 16'hA5C3, 0, 0, 16'hA5C3);

        // Start pulse during COMPARE is ignored.
        run_conv("midstart", 16'h0F0F, 0, 3, 16'h0F0F);

        // Backpressure: result held, starts ignored while waiting.
        vin = 16'h3C96;
        mode = 0;
        dout_ready = 1'b0;
        clear_counts();
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        while (dout_valid !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        check("bp_lat", lat, 35);
        d0 = dout;
        check("bp_dout", {16'h0, d0}, 32'h3C96);
        bad = 0;
        vin = 16'h1234;
        for (int i = 0; i < 10; i++) begin
            start = (i % 2 == 0);
            tick();
            if (dout !== d0 || dout_valid !== 1'b1 || samp !== 1'b0) bad++;
        end
        check("bp_hold", bad, 0);
        dout_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("bp_valid_drop", {31'h0, dout_valid}, 32'h0);
        check("bp_samp_direct", {31'h0, samp}, 32'h1);
        lat = 1;
        while (dout_valid !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        check("bp_lat2", lat, 35);
        check("bp_dout2", {16'h0, dout}, 32'h1234);
        tick();
        tick();

        // Reset during the bit-9 decision, then a clean conversion.
        vin = 16'hA5C3;
        mode = 0;
        clear_counts();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 16; k++) tick();
        check("mid_comp_n", comp_cnt, 7);
        check("mid_cap_bit9", {16'h0, cap_botplate}, 32'hA600);
        rst = 1'b1;
        tick();
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        check("mid_rst_samp", {31'h0, samp}, 32'h0);
        check("mid_rst_comp_clk", {31'h0, comp_clk}, 32'h0);
        check("mid_rst_valid", {31'h0, dout_valid}, 32'h0);
        check("mid_rst_cap", {16'h0, cap_botplate}, 32'h0);
        check("mid_rst_cap_d", {16'h0, cap_botplate_d}, 32'h0);
        check("mid_rst_dout", {16'h0, dout}, 32'h0);
        rst = 1'b0;
        tick();
        run_conv("after_rst", 16'h5A3C, 0, 0, 16'h5A3C);

        // Range extremes and exact mid-scale.
        run_conv("all_low", 16'h0000, 1, 0, 16'hFFFF);
        run_conv("all_high", 16'h0000, 2, 0, 16'h0000);
        run_conv("mid", 16'h8000, 0, 0, 16'h8000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sar_ctrl.md
Name: sar_ctrl

Overview:
- Synchronous SAR sequencer for the capacitive DAC array. Drives its bottom-plate control buses (cap_botplate, cap_botplate_d) and the sampling switch.
- Strobes the external comparator once per bit and resolves Ndac bits MSB-first.
- Presents the converted code on a valid/ready output.
- Sits between the digital readout logic and the analog capacitor array / comparator macros.

Parameters:
- Ndac, 16, number of DAC bits; width of the bottom-plate buses and dout.
- Ntrack, 2, sampling-phase length in clk cycles (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  conversion request; sampled only in IDLE, or in DONE together with dout_ready.
- busy  output  1  high from SAMPLE entry until DONE exit.
- samp  output  1  sampling switch enable (top plate tracks input).
- comp_clk  output  1  comparator strobe, one-cycle pulse.
- comp_out  input  1  comparator decision, valid the cycle after comp_clk. 1 = top plate above threshold.
- cap_botplate  output  Ndac  bottom-plate control word (current trial code).
- cap_botplate_d  output  Ndac  cap_botplate delayed by exactly one clk; used for break-before-make switching.
- dout  output  Ndac  converted code.
- dout_valid  output  1  dout holds a new result.
- dout_ready  input  1  consumer accepts dout.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE. busy, samp, comp_clk, dout_valid = 0. cap_botplate, cap_botplate_d, dout = 0. Reset overrides any state, including mid-conversion; the partial result is discarded.
- cap_botplate_d <= cap_botplate every cycle, except under reset.
- States:
  - IDLE:
    - start=1 -> SAMPLE.
    - cap_botplate loads the mid-scale code (MSB=1, rest 0).
    - Tracking counter cleared.
  - SAMPLE:
    - samp=1 for exactly Ntrack cycles; cap_botplate holds mid-scale.
    - Bit pointer initialised to Ndac-1.
    - Then -> COMPARE.
  - COMPARE:
    - comp_clk=1 for one cycle.
    - -> DECIDE.
  - DECIDE:
    - Sample comp_out.
    - If comp_out=1, clear cap_botplate[ptr].
    - If ptr>0, set cap_botplate[ptr-1], decrement ptr, -> COMPARE.
    - If ptr==0, copy the final word into dout, set dout_valid, -> DONE.
  - DONE:
    - dout/dout_valid held stable until dout_ready=1.
    - On handshake, dout_valid clears; next state is SAMPLE if start=1 that cycle, else IDLE.
    - cap_botplate holds the final code while in DONE.
- Latency: start-accept to dout_valid = Ntrack + 2*Ndac + 1 cycles.
  - Back-to-back conversion period: Ntrack + 2*Ndac + 1 when dout_ready is tied high.
- busy=1 in SAMPLE, COMPARE, DECIDE and DONE.
- start asserted in SAMPLE, COMPARE or DECIDE is ignored (no queueing).
- dout_ready without dout_valid has no effect.
- comp_out is ignored outside DECIDE.
- Bit pointer width is $clog2(Ndac). There is no wrap; the ptr==0 decision terminates the conversion.

Optional Feature:
- Macro: SAR_OVR_EN.
- Defined:
  - Extra output port over_range (1 bit), registered with dout and reset to 0.
  - over_range=1 when the final code is all-ones or all-zeros; it clears on the dout handshake.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package sar_pkg:
  - State enum (IDLE, SAMPLE, COMPARE, DECIDE, DONE).
  - Function returning the mid-scale code for a given Ndac.
  - Localparam for pointer width.
- One natural sub-module, sar_bitreg:
  - Holds the Ndac trial register and bit pointer.
  - Inputs: init, step, comp_out.
  - Outputs: code, last.
- FSM, counters and handshake stay in sar_ctrl.

Test Plan:
- Reset mid-conversion: assert rst during DECIDE at bit 9 -> next cycle all outputs 0, state IDLE; a following start runs a full, correct conversion.
- Ideal comparator (Ndac=16, Ntrack=2), input code 0xA5C3:
  - start -> dout=0xA5C3 with dout_valid after exactly 35 cycles.
  - Exactly 16 comp_clk pulses.
  - samp high for 2 cycles.
- cap_botplate_d check: during any conversion, cap_botplate_d equals the previous-cycle cap_botplate every cycle, including the first SAMPLE cycle (old value 0 after reset).
- Backpressure: dout_ready=0 for 10 cycles after dout_valid -> dout stable, start pulses ignored. Then dout_ready=1 with start=1 -> dout_valid drops and samp=1 next cycle (SAMPLE entered directly).
- start during conversion: pulse start in COMPARE -> no restart, result unchanged, exactly one dout_valid.
- SAR_OVR_EN: with the macro, comparator always 0 gives dout=0xFFFF and over_range=1; always 1 gives dout=0x0000 and over_range=1; code 0x8000 gives over_range=0. Without the macro, the port is absent and the same tests pass on dout.
